// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - MAX7219 register map, power-up configuration ROM and FSM states
package max7219_pkg;

  localparam logic [7:0] ADDR_DECODE     = 8'h09;
  localparam logic [7:0] ADDR_INTENSITY  = 8'h0A;
  localparam logic [7:0] ADDR_SCAN_LIMIT = 8'h0B;
  localparam logic [7:0] ADDR_SHUTDOWN   = 8'h0C;
  localparam logic [7:0] ADDR_TEST       = 8'h0F;

  localparam int INIT_WORDS = 6;

  // Entry 0 is sent first; the intensity entry's data nibble is filled in by the top level.
  localparam logic [INIT_WORDS-1:0][15:0] INIT_ROM = {
    {ADDR_SHUTDOWN,   8'h01},
    {ADDR_SCAN_LIMIT, 8'h07},
    {ADDR_INTENSITY,  8'h00},
    {ADDR_DECODE,     8'h00},
    {ADDR_TEST,       8'h00},
    {ADDR_SHUTDOWN,   8'h00}
  };

  typedef enum logic [2:0] {
    ST_INIT,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_IDLE
  } state_t;

endpackage

// File: rtl/max7219_spi16_tx.sv
// rtl/max7219_spi16_tx.sv - 16-bit MSB-first shifter with registered din/sclk/cs pins
module spi16_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word,
  output logic        din,
  output logic        sclk,
  output logic        cs,
  output logic        done
);

  logic        active;
  logic        tail;
  logic        hi;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [14:0] shreg;
  logic        term_end;

  assign term_end = active && (div_cnt == 8'(CLK_DIV - 1));
  // done marks the last cycle of the trailing low term; cs rises on the next edge.
  assign done     = term_end && tail;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      tail    <= 1'b0;
      hi      <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      din     <= 1'b0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
    end else if (start) begin
      active  <= 1'b1;
      tail    <= 1'b0;
      hi      <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= 4'd15;
      shreg   <= word[14:0];
      din     <= word[15];
      sclk    <= 1'b0;
      cs      <= 1'b0;
    end else if (active) begin
      if (!term_end) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        if (tail) begin
          active <= 1'b0;
          tail   <= 1'b0;
          cs     <= 1'b1;
          din    <= 1'b0;
        end else if (!hi) begin
          hi   <= 1'b1;
          sclk <= 1'b1;
        end else begin
          hi   <= 1'b0;
          sclk <= 1'b0;
          if (bit_cnt == 4'd0) begin
            tail <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 4'd1;
            din     <= shreg[14];
            shreg   <= {shreg[13:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/max7219_matrix_driver.sv
// rtl/max7219_matrix_driver.sv - configures a MAX7219 then streams the 8-word led_user pattern
module max7219_matrix_driver
  import max7219_pkg::*;
#(
  parameter int         CLK_DIV        = 4,
  parameter logic [3:0] INTENSITY      = 4'h8,
  parameter int         REFRESH_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] led_user,
  output logic         din,
  output logic         sclk,
  output logic         cs,
  output logic         busy,
  output logic         pass_done
);

  localparam int            RW           = $clog2(REFRESH_CYCLES);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  state_t         state, state_next;
  logic [2:0]     init_idx;
  logic [2:0]     word_idx;
  logic           data_mode;
  logic [7:0]     lat_cnt;
  logic [127:0]   snapshot;
  logic [127:0]   data_src;
  logic [RW-1:0]  refresh_cnt;
  logic           busy_q;
  logic           tx_start;
  logic           tx_done;
  logic [15:0]    tx_word;
  logic [15:0]    rom_word;
  logic           lat_last;
  logic           trigger;

  // LATCH is one term short; the following INIT/LOAD cycle completes the cs-high term.
  assign lat_last  = (lat_cnt == 8'(CLK_DIV - 2));
  assign trigger   = (led_user != snapshot) || (refresh_cnt == REFRESH_LAST);
  assign pass_done = (state == ST_LATCH) && data_mode && (word_idx == 3'd0) && lat_last;
  assign busy      = busy_q;
  // The first word of a pass is taken straight from led_user as it is being captured.
  assign data_src  = (word_idx == 3'd7) ? led_user : snapshot;

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    rom_word   = INIT_ROM[init_idx];
    if (rom_word[15:8] == ADDR_INTENSITY) rom_word[3:0] = INTENSITY;
    tx_word    = rom_word;
    case (state)
      ST_INIT: begin
        tx_start   = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_LOAD: begin
        tx_start   = 1'b1;
        tx_word    = data_src[{word_idx, 4'b0000} +: 16];
        state_next = ST_SHIFT;
      end
      ST_SHIFT: if (tx_done) state_next = ST_LATCH;
      ST_LATCH: begin
        if (lat_last) begin
          if (!data_mode)
            state_next = (init_idx == 3'(INIT_WORDS - 1)) ? ST_LOAD : ST_INIT;
          else
            state_next = (word_idx == 3'd0) ? ST_IDLE : ST_LOAD;
        end
      end
      ST_IDLE:  if (trigger) state_next = ST_LOAD;
      default:  state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_INIT;
      init_idx    <= '0;
      word_idx    <= 3'd7;
      data_mode   <= 1'b0;
      lat_cnt     <= '0;
      snapshot    <= '0;
      refresh_cnt <= '0;
      busy_q      <= 1'b0;
    end else begin
      state   <= state_next;
      busy_q  <= (state_next != ST_IDLE);
      lat_cnt <= (state == ST_LATCH) ? lat_cnt + 8'd1 : 8'd0;
      if (state == ST_LATCH && lat_last) begin
        if (!data_mode) begin
          if (init_idx == 3'(INIT_WORDS - 1)) begin
            data_mode <= 1'b1;
            word_idx  <= 3'd7;
          end else begin
            init_idx <= init_idx + 3'd1;
          end
        end else if (word_idx != 3'd0) begin
          word_idx <= word_idx - 3'd1;
        end
      end
      if (state == ST_IDLE && trigger) word_idx <= 3'd7;
      if (state == ST_LOAD && word_idx == 3'd7) snapshot <= led_user;
      if (state == ST_LOAD)
        refresh_cnt <= '0;
      else if (state == ST_IDLE && refresh_cnt != REFRESH_LAST)
        refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  spi16_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .word  (tx_word),
    .din   (din),
    .sclk  (sclk),
    .cs    (cs),
    .done  (tx_done)
  );

endmodule
